uart_tx_buf: RTL and testbench

UART transmit path with an on-chip transmit buffer. Bytes written from the local logic are held in a synchronous FIFO, then serialised onto txd as 8N1 frames (or 8N2), LSB first. Frames are paced by an externally supplied one-tick-per-bit enable. The block sits beside the UART receive path and shares its baud-tick source and overflow-reporting convention.

---
 rtl/uart_tx_buf.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_buf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// UART transmitter with a synchronous byte FIFO in front of an 8N1/8N2
// serialiser paced by an external one-tick-per-bit enable.
module uart_tx_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  tx_fifo_wen,
    input  logic [7:0]            tx_fifo_wdata,
    output logic                  tx_fifo_full,
    output logic                  tx_fifo_empty,
    output logic [DEPTH_LOG2:0]   tx_fifo_usedw,
    output logic                  tx_overflow,
    input  logic                  clr_ovf,
    output logic                  txd,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int UW    = DEPTH_LOG2 + 1;
    localparam logic [UW-1:0] DEPTH_W   = UW'(DEPTH);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]         usedw_q, usedw_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    state_t                state_q, state_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  txd_q, txd_d;
    logic                  wr_acc;
    logic                  pop;
    logic [7:0]            rd_data;

    always_comb begin
        rd_data = mem_q[rd_ptr_q];
        wr_acc  = tx_fifo_wen && !full_q;
        pop     = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shreg_d = rd_data;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d = 1'b1;
                    end
                end
                START: begin
                    txd_d   = shreg_q[0];
                    cnt_d   = 4'd1;
                    state_d = DATA;
                end
                DATA: begin
                    if (cnt_q < 4'd8) begin
                        txd_d = shreg_q[cnt_q[2:0]];
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        txd_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (cnt_q != LAST_STOP) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (!empty_q) begin
                        // chain straight into the next start bit
                        pop     = 1'b1;
                        shreg_d = rd_data;
                        txd_d   = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = START;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr_acc);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
        usedw_d  = usedw_q;
        unique case ({wr_acc, pop})
            2'b10:   usedw_d = usedw_q + UW'(1);
            2'b01:   usedw_d = usedw_q - UW'(1);
            default: usedw_d = usedw_q;
        endcase
        full_d  = (usedw_d == DEPTH_W);
        empty_d = (usedw_d == '0);
        ovf_d   = ovf_q;
        // a refused write takes priority over a clear in the same cycle
        if (tx_fifo_wen && full_q) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= tx_fifo_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            txd_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            txd_q    <= txd_d;
        end
    end

    assign tx_fifo_full  = full_q;
    assign tx_fifo_empty = empty_q;
    assign tx_fifo_usedw = usedw_q;
    assign tx_overflow   = ovf_q;
    assign txd           = txd_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: one instance with one stop bit and
// one with two stop bits, sharing clock, reset and bit tick.
module tb_uart_tx_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;

    logic       wen = 1'b0;
    logic [7:0] wdata = '0;
    logic       clr = 1'b0;
    logic       full, empty, ovf, txd, busy;
    logic [4:0] usedw;

    logic       wen2 = 1'b0;
    logic [7:0] wdata2 = '0;
    logic       clr2 = 1'b0;
    logic       full2, empty2, ovf2, txd2, busy2;
    logic [4:0] usedw2;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_buf #(.DEPTH_LOG2(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .tx_fifo_wen(wen), .tx_fifo_wdata(wdata),
        .tx_fifo_full(full), .tx_fifo_empty(empty),
        .tx_fifo_usedw(usedw), .tx_overflow(ovf),
        .clr_ovf(clr), .txd(txd), .busy(busy)
    );

    uart_tx_buf #(.DEPTH_LOG2(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .ena(ena),
        .tx_fifo_wen(wen2), .tx_fifo_wdata(wdata2),
        .tx_fifo_full(full2), .tx_fifo_empty(empty2),
        .tx_fifo_usedw(usedw2), .tx_overflow(ovf2),
        .clr_ovf(clr2), .txd(txd2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one bit period: ena for one clk, then three idle clks
    task automatic tick();
        ena = 1'b1;
        step();
        ena = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic put(input logic [7:0] d);
        wen   = 1'b1;
        wdata = d;
        step();
        wen   = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b, output logic s,
                           output logic p);
        tick();
        s = txd;
        for (int i = 0; i < 8; i++) begin
            tick();
            b[i] = txd;
        end
        tick();
        p = txd;
    endtask

    logic [9:0]  f_a5;
    logic [29:0] stream;
    logic [7:0]  b;
    logic        s, p;
    int          err_cnt;
    int          hi_cnt;

    initial begin
        step();
        step();
        rst = 1'b0;
        step();

        // reset state
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_usedw", usedw, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_txd2", txd2, 1);

        // single 0xA5 frame, LSB first
        f_a5 = 10'b11_0100_1010;
        put(8'hA5);
        check("a5_usedw", usedw, 1);
        step();
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("a5_bit%0d", i), txd, f_a5[i]);
            check($sformatf("a5_busy%0d", i), busy, 1);
        end
        tick();
        check("a5_idle_txd", txd, 1);
        check("a5_idle_busy", busy, 0);
        check("a5_idle_empty", empty, 1);

        // three back-to-back frames
        put(8'h01);
        put(8'h02);
        put(8'h03);
        check("b2b_usedw", usedw, 3);
        stream = {1'b1, 8'h03, 1'b0,
                  1'b1, 8'h02, 1'b0,
                  1'b1, 8'h01, 1'b0};
        err_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (txd !== stream[i]) err_cnt++;
            if (busy !== 1'b1) err_cnt++;
        end
        check("b2b_stream_errs", err_cnt, 0);
        tick();
        check("b2b_end_busy", busy, 0);
        check("b2b_end_txd", txd, 1);

        // fill to full with ena held low, then overflow
        for (int i = 0; i < 16; i++) put(8'(i));
        check("fill_full", full, 1);
        check("fill_usedw", usedw, 16);
        check("fill_ovf_pre", ovf, 0);
        put(8'h10);
        check("ovf_set", ovf, 1);
        check("ovf_usedw", usedw, 16);
        wen = 1'b1;
        wdata = 8'h55;
        clr = 1'b1;
        step();
        wen = 1'b0;
        clr = 1'b0;
        check("ovf_set_wins", ovf, 1);
        for (int k = 0; k < 16; k++) begin
            rx_byte(b, s, p);
            check($sformatf("drain_start%0d", k), s, 0);
            check($sformatf("drain_byte%0d", k), b, k);
            check($sformatf("drain_stop%0d", k), p, 1);
        end
        check("drain_empty", empty, 1);
        tick();
        check("drain_idle_busy", busy, 0);
        check("drain_ovf_kept", ovf, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovf_clr", ovf, 0);

        // write and pop in the same cycle at usedw=1
        put(8'h3C);
        step();
        check("wp_usedw_pre", usedw, 1);
        ena = 1'b1;
        wen = 1'b1;
        wdata = 8'hC3;
        step();
        ena = 1'b0;
        wen = 1'b0;
        check("wp_usedw", usedw, 1);
        check("wp_start", txd, 0);
        step();
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            tick();
            b[i] = txd;
        end
        check("wp_byte0", b, 8'h3C);
        tick();
        check("wp_stop0", txd, 1);
        rx_byte(b, s, p);
        check("wp_byte1", b, 8'hC3);
        check("wp_start1", s, 0);
        check("wp_stop1", p, 1);
        tick();
        check("wp_idle", busy, 0);

        // reset in DATA of the second of four queued frames
        put(8'h11);
        put(8'h22);
        put(8'h33);
        put(8'h44);
        for (int i = 0; i < 12; i++) tick();
        check("mid_busy", busy, 1);
        check("mid_txd", txd, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_usedw", usedw, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_busy", busy, 0);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (txd === 1'b1 && busy === 1'b0) hi_cnt++;
        end
        check("mid_quiet", hi_cnt, 20);

        // two stop bits, 0xFF
        wen2 = 1'b1;
        wdata2 = 8'hFF;
        step();
        wen2 = 1'b0;
        step();
        tick();
        check("sb2_start", txd2, 0);
        err_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (txd2 !== 1'b1) err_cnt++;
            if (busy2 !== 1'b1) err_cnt++;
        end
        check("sb2_ones", err_cnt, 0);
        tick();
        check("sb2_end_busy", busy2, 0);
        check("sb2_end_txd", txd2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
